// File: rtl/ic_refill_responder_pkg.sv
// rtl/ic_refill_responder_pkg.sv - shared types and default line geometry for the I-cache refill responder
package ic_refill_responder_pkg;

    localparam int IC_TAG_BITS      = 20;
    localparam int IC_INDEX_BITS    = 7;
    localparam int IC_LINE_BITS     = 256;
    localparam int IC_MEM_DATA_BITS = 64;

    // Beat counter width: at least one bit so a single-beat line still has a legal counter.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    localparam int BEATS    = IC_LINE_BITS / IC_MEM_DATA_BITS;
    localparam int BEAT_LOG = clog2_min1(BEATS);
    localparam int OFF      = $clog2(IC_LINE_BITS / 8);

    typedef struct packed {
        logic [IC_TAG_BITS-1:0]   tag;
        logic [IC_INDEX_BITS-1:0] index;
    } icRefillReq_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} icRefillState_t;

endpackage

// File: rtl/ic_refill_req_fifo.sv
// rtl/ic_refill_req_fifo.sv - pending-refill queue with a parallel address match across all live entries
module ic_refill_req_fifo
    import ic_refill_responder_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = icRefillReq_t
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  entry_t                 match_data,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic                   match,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             entries [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    assign head  = entries[rd_ptr];
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);

    // A push into the slot being popped (full queue) must leave that slot valid, so push is applied last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                valid[wr_ptr]   <= 1'b1;
                entries[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Any live entry, including the head still being fetched, counts as a match.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i] == match_data)) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ic_refill_responder.sv
// rtl/ic_refill_responder.sv - queues I-cache refill requests and assembles lines from memory beats
module ic_refill_responder
    import ic_refill_responder_pkg::*;
#(
    parameter int TAG_BITS       = IC_TAG_BITS,
    parameter int INDEX_BITS     = IC_INDEX_BITS,
    parameter int LINE_BITS      = IC_LINE_BITS,
    parameter int MEM_DATA_BITS  = IC_MEM_DATA_BITS,
    parameter int REQ_FIFO_DEPTH = 4
)(
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [TAG_BITS+INDEX_BITS-1:0]                         ic2memReqAddr_i,
    input  logic                                                   ic2memReqValid_i,
    output logic [TAG_BITS-1:0]                                    mem2icTag_o,
    output logic [INDEX_BITS-1:0]                                  mem2icIndex_o,
    output logic [LINE_BITS-1:0]                                   mem2icData_o,
    output logic                                                   mem2icRespValid_o,
    output logic [TAG_BITS+INDEX_BITS+$clog2(LINE_BITS/8)-1:0]     memRdAddr_o,
    output logic                                                   memRdReq_o,
    input  logic                                                   memRdGnt_i,
    input  logic [MEM_DATA_BITS-1:0]                               memRdData_i,
    input  logic                                                   memRdDataValid_i,
    output logic                                                   reqDrop_o,
    output logic                                                   protocolErr_o
);

    localparam int BLOCK_ADDR_BITS = TAG_BITS + INDEX_BITS;
    localparam int N_BEATS         = LINE_BITS / MEM_DATA_BITS;
    localparam int N_BEAT_LOG      = clog2_min1(N_BEATS);
    localparam int LINE_OFF        = $clog2(LINE_BITS / 8);
    localparam int BEAT_SHIFT      = $clog2(MEM_DATA_BITS / 8);
    localparam int ADDR_BITS       = BLOCK_ADDR_BITS + LINE_OFF;
    localparam int CNT_W           = $clog2(REQ_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [TAG_BITS-1:0]   tag;
        logic [INDEX_BITS-1:0] index;
    } req_t;

    icRefillState_t          state;
    logic [N_BEAT_LOG-1:0]   cnt;
    logic [LINE_BITS-1:0]    line_q;
    logic [LINE_BITS-1:0]    line_next;
    req_t                    req_in;
    req_t                    head;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic                    match;
    logic                    drop;
    logic [CNT_W-1:0]        count;

    assign req_in = req_t'(ic2memReqAddr_i);
    assign pop    = (state == RESP);
    // A full queue still accepts a request in the cycle its head is returned.
    assign push   = ic2memReqValid_i && !match && (!full || pop);
    assign drop   = ic2memReqValid_i && !match && full && !pop;

    assign memRdAddr_o = memRdReq_o
                       ? ((ADDR_BITS'(head) << LINE_OFF) | (ADDR_BITS'(cnt) << BEAT_SHIFT))
                       : '0;

    ic_refill_req_fifo #(
        .DEPTH   (REQ_FIFO_DEPTH),
        .entry_t (req_t)
    ) u_req_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (req_in),
        .pop        (pop),
        .match_data (req_in),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .match      (match),
        .count      (count)
    );

    // Line buffer with the arriving beat merged in at the current beat position.
    always_comb begin
        line_next = line_q;
        for (int b = 0; b < N_BEATS; b++) begin
            if (cnt == N_BEAT_LOG'(b)) begin
                line_next[b*MEM_DATA_BITS +: MEM_DATA_BITS] = memRdData_i;
            end
        end
    end

    // Refill sequencer: issue one beat read at a time, collect beats, pulse the finished line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            cnt               <= '0;
            line_q            <= '0;
            memRdReq_o        <= 1'b0;
            mem2icRespValid_o <= 1'b0;
            mem2icTag_o       <= '0;
            mem2icIndex_o     <= '0;
            mem2icData_o      <= '0;
            reqDrop_o         <= 1'b0;
            protocolErr_o     <= 1'b0;
        end else begin
            reqDrop_o         <= drop;
            mem2icRespValid_o <= 1'b0;
            if (memRdDataValid_i && (state != WAIT)) begin
                protocolErr_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!empty || push) begin
                        state      <= ISSUE;
                        cnt        <= '0;
                        memRdReq_o <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (memRdGnt_i) begin
                        state      <= WAIT;
                        memRdReq_o <= 1'b0;
                    end
                end
                WAIT: begin
                    if (memRdDataValid_i) begin
                        line_q <= line_next;
                        if (cnt == N_BEAT_LOG'(N_BEATS - 1)) begin
                            state             <= RESP;
                            mem2icRespValid_o <= 1'b1;
                            mem2icTag_o       <= head.tag;
                            mem2icIndex_o     <= head.index;
                            mem2icData_o      <= line_next;
                        end else begin
                            cnt        <= cnt + 1'b1;
                            state      <= ISSUE;
                            memRdReq_o <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    cnt <= '0;
                    if ((count > CNT_W'(1)) || push) begin
                        state      <= ISSUE;
                        memRdReq_o <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
